sccb_slave: RTL and testbench
=============================

SCCB_SLAVE -- requirements
Module: sccb_slave

Interface
REQ-001 SHALL have parameter DEV_ID, default 8'h42, 7-bit device ID in [7:1]; bit 0 ignored.
REQ-002 SHALL have port clk_i  input  1  main clock, at least 16x SIOC frequency.
REQ-003 SHALL have port rst_i  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port sioc_i  input  1  SCCB clock from master.
REQ-005 SHALL have port siod_io  inout  1  SCCB data, open-drain: drive 0 or release to z, never drive 1.
REQ-006 SHALL have port reg_addr_o  output  8  latched register sub-address.
REQ-007 SHALL have port reg_wdata_o  output  8  received write data.
REQ-008 SHALL have port reg_we_o  output  1  one-clk write strobe.
REQ-009 SHALL have port reg_re_o  output  1  one-clk read strobe; reg_rdata_i sampled the same cycle.
REQ-010 SHALL have port reg_rdata_i  input  8  register read data.
REQ-011 SHALL have port busy_o  output  1  high from START to STOP/abort.

Function
REQ-012 SHALL synchronise sioc_i and siod_io through 2 flops; all decisions use synchronised values and their edges.
REQ-013 START = SIOD falling while SIOC high; STOP = SIOD rising while SIOC high; both are valid in any state.
REQ-014 SHALL sample SIOD on SIOC rising edges and change its SIOD drive within 3 clk_i of SIOC falling edges.
REQ-015 States: IDLE, DEV_ID, ACK_ID, SUB_ADDR, ACK_SUB, WR_DATA, ACK_WR, RD_DATA, RD_NACK, WAIT_STOP; a 4-bit bit counter counts 0..8.
REQ-016 START in any state -> DEV_ID with bit counter cleared (repeated start supported); STOP in any state -> IDLE with SIOD released.
REQ-017 DEV_ID: shift 8 bits MSB first; on [7:1]==DEV_ID[7:1] -> ACK_ID and drive 0 for the 9th clock; on mismatch -> WAIT_STOP, SIOD released.
REQ-018 After ACK_ID: bit0=0 -> SUB_ADDR; bit0=1 -> RD_DATA.
REQ-019 SUB_ADDR: 8 bits -> reg_addr_o updated, ACK_SUB drives 0 -> WR_DATA.
REQ-020 WR_DATA: 8 bits -> reg_wdata_o updated, ACK_WR drives 0, reg_we_o pulsed once -> WAIT_STOP; extra bytes are not acknowledged.
REQ-021 A write ending after SUB_ADDR (2-phase) SHALL retain reg_addr_o for a following read; there is no auto-increment.
REQ-022 RD_DATA: pulse reg_re_o and load reg_rdata_i into the shift register on the SIOC falling edge that ends ACK_ID; drive 0-bits / release 1-bits MSB first, one per SIOC low phase.
REQ-023 RD_NACK: release SIOD for the 9th clock, ignore the master's ack value -> WAIT_STOP.
REQ-024 A STOP or START arriving mid-byte SHALL discard the partial byte; no reg_we_o or reg_re_o is generated.
REQ-025 busy_o SHALL be 1 in every state except IDLE.

Reset
REQ-026 On rst_i=0, immediately: state IDLE, SIOD released (z), reg_addr_o=0, reg_wdata_o=0, reg_we_o=0, reg_re_o=0, busy_o=0, sync flops=1.
REQ-027 Reset mid-transaction SHALL abort without a strobe; after release, the block SHALL wait for a fresh START.

Structure
REQ-028 Package sccb_pkg SHALL hold the state enum, the default DEV_ID and the bit-counter width.
REQ-029 One sub-module, sccb_line_sync (2-flop sync + rise/fall detect), SHALL be instantiated once per line.

Verification
REQ-030 Write 0x42,0x12,0x80 + STOP -> three ACKs (SIOD 0 on each 9th clock); one reg_we_o with addr 0x12 and data 0x80; busy_o returns to 0.
REQ-031 Write 0x42,0x0A, STOP; START 0x43 with reg_rdata_i=0x76 -> ACK; one reg_re_o with reg_addr_o=0x0A; SIOD bits 0,1,1,1,0,1,1,0; master NACK then STOP -> IDLE.
REQ-032 ID 0x60,0x12,0x80 -> SIOD stays high on every 9th clock; no strobes; IDLE after STOP.
REQ-033 0x42,0x12, then 4 data bits, then STOP -> no reg_we_o; reg_addr_o=0x12; busy_o=0.
REQ-034 rst_i low during RD_DATA while driving 0 -> SIOD z within 1 clk; busy_o=0; the next 0x43 read completes normally.
REQ-035 0x42,0x34, repeated START, 0x43 -> reg_re_o with addr 0x34 and no reg_we_o.

Source files
------------

// File: rtl/sccb_pkg.sv
// rtl/sccb_pkg.sv - shared types and constants for the SCCB slave
package sccb_pkg;

  localparam logic [7:0] DEV_ID_DEFAULT = 8'h42;
  localparam int BIT_CNT_W = 4;
  localparam logic [BIT_CNT_W-1:0] BYTE_BITS = BIT_CNT_W'(8);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_DEV_ID,
    ST_ACK_ID,
    ST_SUB_ADDR,
    ST_ACK_SUB,
    ST_WR_DATA,
    ST_ACK_WR,
    ST_RD_DATA,
    ST_RD_NACK,
    ST_WAIT_STOP
  } sccb_state_e;

  // Only the 7 address bits take part; bit 0 is the read/write flag.
  function automatic logic id_match(input logic [7:0] rx_byte, input logic [7:0] dev_id);
    return rx_byte[7:1] == dev_id[7:1];
  endfunction

endpackage

// File: rtl/sccb_line_sync.sv
// rtl/sccb_line_sync.sv - two-flop synchroniser with rise/fall detection for one SCCB line
module sccb_line_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic line_i,
  output logic line_o,
  output logic rise_o,
  output logic fall_o
);

  logic [1:0] sync_q, sync_d;
  logic       prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[0], line_i};
    prev_d = sync_q[1];
  end

  // Idle bus level is high, so reset to 1 to avoid a phantom edge on release.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sync_q <= 2'b11;
      prev_q <= 1'b1;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign line_o = sync_q[1];
  assign rise_o = sync_q[1] & ~prev_q;
  assign fall_o = ~sync_q[1] & prev_q;

endmodule

// File: rtl/sccb_slave.sv
// rtl/sccb_slave.sv - SCCB (two-wire) register-access slave with open-drain SIOD
module sccb_slave
  import sccb_pkg::*;
#(
  parameter logic [7:0] DEV_ID = DEV_ID_DEFAULT
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       sioc_i,
  inout  wire        siod_io,
  output logic [7:0] reg_addr_o,
  output logic [7:0] reg_wdata_o,
  output logic       reg_we_o,
  output logic       reg_re_o,
  input  logic [7:0] reg_rdata_i,
  output logic       busy_o
);

  logic scl_line, scl_rise, scl_fall;
  logic sda_line, sda_rise, sda_fall;

  sccb_line_sync u_scl_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .line_i(sioc_i),
    .line_o(scl_line),
    .rise_o(scl_rise),
    .fall_o(scl_fall)
  );

  sccb_line_sync u_sda_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .line_i(siod_io),
    .line_o(sda_line),
    .rise_o(sda_rise),
    .fall_o(sda_fall)
  );

  sccb_state_e          state_q, state_d;
  logic [BIT_CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]           shift_q, shift_d;
  logic [7:0]           addr_q, addr_d;
  logic [7:0]           wdata_q, wdata_d;
  logic                 rw_q, rw_d;
  logic                 oe_q, oe_d;
  logic                 we_q, we_d;
  logic                 re_q, re_d;
  logic                 busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rw_d    = rw_q;
    oe_d    = oe_q;
    we_d    = 1'b0;
    re_d    = 1'b0;

    if (sda_fall && scl_line) begin
      state_d = ST_DEV_ID;
      cnt_d   = '0;
      oe_d    = 1'b0;
    end else if (sda_rise && scl_line) begin
      state_d = ST_IDLE;
      oe_d    = 1'b0;
    end else begin
      // Read data is captured in the strobe cycle, then its MSB goes on the line.
      if (re_q) begin
        shift_d = reg_rdata_i;
        oe_d    = ~reg_rdata_i[7];
      end
      if (scl_rise && (state_q inside {ST_DEV_ID, ST_SUB_ADDR, ST_WR_DATA, ST_RD_DATA})) begin
        cnt_d = cnt_q + 1'b1;
        if (state_q != ST_RD_DATA) shift_d = {shift_q[6:0], sda_line};
      end
      if (scl_fall) begin
        unique case (state_q)
          ST_DEV_ID: begin
            if (cnt_q == BYTE_BITS) begin
              cnt_d = '0;
              rw_d  = shift_q[0];
              if (id_match(shift_q, DEV_ID)) begin
                state_d = ST_ACK_ID;
                oe_d    = 1'b1;
              end else begin
                state_d = ST_WAIT_STOP;
              end
            end
          end
          ST_ACK_ID: begin
            cnt_d = '0;
            oe_d  = 1'b0;
            if (rw_q) begin
              state_d = ST_RD_DATA;
              re_d    = 1'b1;
            end else begin
              state_d = ST_SUB_ADDR;
            end
          end
          ST_SUB_ADDR: begin
            if (cnt_q == BYTE_BITS) begin
              cnt_d   = '0;
              addr_d  = shift_q;
              state_d = ST_ACK_SUB;
              oe_d    = 1'b1;
            end
          end
          ST_ACK_SUB: begin
            cnt_d   = '0;
            state_d = ST_WR_DATA;
            oe_d    = 1'b0;
          end
          ST_WR_DATA: begin
            if (cnt_q == BYTE_BITS) begin
              cnt_d   = '0;
              wdata_d = shift_q;
              we_d    = 1'b1;
              state_d = ST_ACK_WR;
              oe_d    = 1'b1;
            end
          end
          ST_ACK_WR: begin
            state_d = ST_WAIT_STOP;
            oe_d    = 1'b0;
          end
          ST_RD_DATA: begin
            if (cnt_q == BYTE_BITS) begin
              state_d = ST_RD_NACK;
              oe_d    = 1'b0;
            end else begin
              shift_d = {shift_q[6:0], 1'b0};
              oe_d    = ~shift_q[6];
            end
          end
          ST_RD_NACK: state_d = ST_WAIT_STOP;
          default: ;
        endcase
      end
    end
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rw_q    <= 1'b0;
      oe_q    <= 1'b0;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rw_q    <= rw_d;
      oe_q    <= oe_d;
      we_q    <= we_d;
      re_q    <= re_d;
      busy_q  <= busy_d;
    end
  end

  assign siod_io     = oe_q ? 1'b0 : 1'bz;
  assign reg_addr_o  = addr_q;
  assign reg_wdata_o = wdata_q;
  assign reg_we_o    = we_q;
  assign reg_re_o    = re_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_sccb_slave.sv
// tb/tb_sccb_slave.sv - self-checking bench for sccb_slave with a bus-level master and register model
module tb_sccb_slave;

  localparam int Q = 50;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl = 1'b1;
  logic       m_low = 1'b0;
  logic [7:0] rdata = 8'h00;
  wire        siod;
  logic [7:0] reg_addr, reg_wdata;
  logic       reg_we, reg_re, busy;

  pullup (siod);
  assign siod = m_low ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  sccb_slave #(.DEV_ID(8'h42)) dut (
    .clk_i      (clk),
    .rst_i      (rst_n),
    .sioc_i     (scl),
    .siod_io    (siod),
    .reg_addr_o (reg_addr),
    .reg_wdata_o(reg_wdata),
    .reg_we_o   (reg_we),
    .reg_re_o   (reg_re),
    .reg_rdata_i(rdata),
    .busy_o     (busy)
  );

  int         n_checks = 0;
  int         n_fail = 0;
  int         we_cnt = 0;
  int         re_cnt = 0;
  logic [7:0] we_addr = 8'h00, we_data = 8'h00, re_addr = 8'h00;

  always @(negedge clk) begin
    if (reg_we) begin
      we_cnt++;
      we_addr = reg_addr;
      we_data = reg_wdata;
    end
    if (reg_re) begin
      re_cnt++;
      re_addr = reg_addr;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bit_xfer(input logic b, output logic seen);
    m_low = ~b;
    #Q scl = 1'b1;
    #Q seen = (siod !== 1'b0);
    #Q scl = 1'b0;
    #Q;
  endtask

  task automatic bus_start;
    m_low = 1'b0;
    #Q scl = 1'b1;
    #Q m_low = 1'b1;
    #Q scl = 1'b0;
    #Q;
  endtask

  task automatic bus_stop;
    m_low = 1'b1;
    #Q scl = 1'b1;
    #Q m_low = 1'b0;
    #Q;
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_xfer(b[i], s);
    bit_xfer(1'b1, s);
    ack = ~s;
  endtask

  task automatic read_byte(output logic [7:0] d, input logic nack);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_xfer(1'b1, s);
      d[i] = s;
    end
    bit_xfer(nack, s);
  endtask

  logic       a1, a2, a3, s;
  logic [7:0] d, ra, rw, rr, bad_id;
  int         exp_we, exp_re;
  logic [7:0] exp_addr;

  initial begin
    #23;
    chk("reset_addr", reg_addr, 8'h00);
    chk("reset_wdata", reg_wdata, 8'h00);
    chk("reset_we", reg_we, 1'b0);
    chk("reset_re", reg_re, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_siod_released", siod !== 1'b0, 1'b1);
    #17 rst_n = 1'b1;
    #200;

    // three-phase write
    bus_start();
    #Q chk("busy_after_start", busy, 1'b1);
    write_byte(8'h42, a1);
    write_byte(8'h12, a2);
    write_byte(8'h80, a3);
    bus_stop();
    #100;
    chk("wr_ack_id", a1, 1'b1);
    chk("wr_ack_sub", a2, 1'b1);
    chk("wr_ack_data", a3, 1'b1);
    chk("wr_we_cnt", we_cnt, 1);
    chk("wr_we_addr", we_addr, 8'h12);
    chk("wr_we_data", we_data, 8'h80);
    chk("wr_re_cnt", re_cnt, 0);
    chk("wr_busy_end", busy, 1'b0);

    // two-phase write then read
    bus_start();
    write_byte(8'h42, a1);
    write_byte(8'h0A, a2);
    bus_stop();
    rdata = 8'h76;
    bus_start();
    write_byte(8'h43, a3);
    read_byte(d, 1'b1);
    bus_stop();
    #100;
    chk("rd_ack_setup", {a1, a2}, 2'b11);
    chk("rd_ack_id", a3, 1'b1);
    chk("rd_re_cnt", re_cnt, 1);
    chk("rd_re_addr", re_addr, 8'h0A);
    chk("rd_data", d, 8'h76);
    chk("rd_we_cnt", we_cnt, 1);
    chk("rd_busy_end", busy, 1'b0);

    // wrong device ID
    bus_start();
    write_byte(8'h60, a1);
    write_byte(8'h12, a2);
    write_byte(8'h80, a3);
    bus_stop();
    #100;
    chk("badid_acks", {a1, a2, a3}, 3'b000);
    chk("badid_we_cnt", we_cnt, 1);
    chk("badid_re_cnt", re_cnt, 1);
    chk("badid_busy", busy, 1'b0);

    // partial data byte then STOP
    bus_start();
    write_byte(8'h42, a1);
    write_byte(8'h12, a2);
    bit_xfer(1'b1, s);
    bit_xfer(1'b0, s);
    bit_xfer(1'b1, s);
    bit_xfer(1'b0, s);
    bus_stop();
    #100;
    chk("partial_we_cnt", we_cnt, 1);
    chk("partial_addr", reg_addr, 8'h12);
    chk("partial_busy", busy, 1'b0);

    // reset while slave drives a 0 data bit
    rdata = 8'h36;
    bus_start();
    write_byte(8'h43, a1);
    chk("rst_ack_id", a1, 1'b1);
    chk("rst_driving_zero", siod === 1'b0, 1'b1);
    chk("rst_re_cnt", re_cnt, 2);
    rst_n = 1'b0;
    #3;
    chk("rst_siod_released", siod !== 1'b0, 1'b1);
    chk("rst_busy", busy, 1'b0);
    #20 rst_n = 1'b1;
    bus_stop();
    #100;
    rdata = 8'h76;
    bus_start();
    write_byte(8'h43, a1);
    read_byte(d, 1'b1);
    bus_stop();
    #100;
    chk("post_rst_ack", a1, 1'b1);
    chk("post_rst_data", d, 8'h76);
    chk("post_rst_re_cnt", re_cnt, 3);
    chk("post_rst_we_cnt", we_cnt, 1);
    chk("post_rst_busy", busy, 1'b0);

    // repeated START between sub-address and read
    rdata = 8'hC5;
    bus_start();
    write_byte(8'h42, a1);
    write_byte(8'h34, a2);
    bus_start();
    write_byte(8'h43, a3);
    read_byte(d, 1'b1);
    bus_stop();
    #100;
    chk("rs_acks", {a1, a2, a3}, 3'b111);
    chk("rs_re_cnt", re_cnt, 4);
    chk("rs_re_addr", re_addr, 8'h34);
    chk("rs_data", d, 8'hC5);
    chk("rs_we_cnt", we_cnt, 1);

    // randomized write/read/bad-ID rounds against a register-level model
    exp_we = 1;
    exp_re = 4;
    for (int k = 0; k < 6; k++) begin
      ra = 8'($urandom);
      rw = 8'($urandom);
      rr = 8'($urandom);
      bad_id = 8'($urandom);
      if (bad_id[7:1] == 7'h21) bad_id[7] = ~bad_id[7];

      bus_start();
      write_byte(8'h42, a1);
      write_byte(ra, a2);
      write_byte(rw, a3);
      bus_stop();
      exp_we++;
      exp_addr = ra;
      #100;
      chk("rnd_wr_acks", {a1, a2, a3}, 3'b111);
      chk("rnd_we_cnt", we_cnt, exp_we);
      chk("rnd_we_addr", we_addr, exp_addr);
      chk("rnd_we_data", we_data, rw);

      rdata = rr;
      bus_start();
      write_byte(8'h43, a1);
      read_byte(d, 1'b1);
      bus_stop();
      exp_re++;
      #100;
      chk("rnd_rd_ack", a1, 1'b1);
      chk("rnd_rd_data", d, rr);
      chk("rnd_re_cnt", re_cnt, exp_re);
      chk("rnd_re_addr", re_addr, exp_addr);

      bus_start();
      write_byte(bad_id, a1);
      write_byte(8'($urandom), a2);
      bus_stop();
      #100;
      chk("rnd_bad_acks", {a1, a2}, 2'b00);
      chk("rnd_bad_cnts", {we_cnt[15:0], re_cnt[15:0]}, {exp_we[15:0], exp_re[15:0]});
      chk("rnd_bad_busy", busy, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
